// File: rtl/toy_regfile_sb.sv
// toy_regfile_sb: register file with zero-latency write-through reads and a
// one-bit-per-register pending-write scoreboard (BUSY / OUTSTANDING / ERR).
// Optional build macro: TOY_REGFILE_R0_ZERO_EN -- register 0 hardwired to zero.
// Legal NRD range is 1..4.

// One read port: bypass of the in-flight write, else the stored value.
// BUSY comes from registered pend only, so a same-cycle issue or write-back
// does not show up until the following cycle.
module toy_regfile_sb_rdport #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic [(2**AW)-1:0][DW-1:0] mem,
    input  logic [(2**AW)-1:0]         pend,
    input  logic                       wen,
    input  logic [AW-1:0]              wa,
    input  logic [DW-1:0]              di,
    input  logic [AW-1:0]              ra,
    output logic [DW-1:0]              dout,
    output logic                       busy
);

    // combinational read with write-through bypass
    always_comb begin
        dout = (wen && (wa == ra)) ? di : mem[ra];
        busy = pend[ra];
    end

endmodule

module toy_regfile_sb #(
    parameter int AW  = 5,
    parameter int DW  = 32,
    parameter int NRD = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WEN,
    input  logic [AW-1:0]     WA,
    input  logic [DW-1:0]     DI,
    input  logic [NRD*AW-1:0] RA,
    output logic [NRD*DW-1:0] DOUT,
    input  logic              ISSUE,
    input  logic [AW-1:0]     ISSUE_RD,
    output logic [NRD-1:0]    BUSY,
    output logic [AW:0]       OUTSTANDING,
    output logic              ERR
);

    localparam int ENTRY = 2**AW;

    logic [ENTRY-1:0][DW-1:0] mem;
    logic [ENTRY-1:0]         pend;
    logic [AW:0]              cnt;
    logic                     err;

    // effective enables: with R0 hardwired, anything aimed at register 0 is
    // dropped here so storage, scoreboard and bypass all see nothing
    logic wen_e;
    logic iss_e;
`ifdef TOY_REGFILE_R0_ZERO_EN
    assign wen_e = WEN   && (WA != '0);
    assign iss_e = ISSUE && (ISSUE_RD != '0);
`else
    assign wen_e = WEN;
    assign iss_e = ISSUE;
`endif

    // counter tracks popcount(pend) incrementally: +1 for a fresh pending
    // register, -1 for a write-back that retires one; a write-back to the
    // register being re-issued this cycle does not retire it
    logic cnt_inc;
    logic cnt_dec;
    assign cnt_inc = iss_e && !pend[ISSUE_RD];
    assign cnt_dec = wen_e && pend[WA] && !(iss_e && (ISSUE_RD == WA));

    // storage, scoreboard, outstanding count and sticky error
    always_ff @(posedge CLK) begin
        if (RST) begin
            mem  <= '0;
            pend <= '0;
            cnt  <= '0;
            err  <= 1'b0;
        end else begin
            if (wen_e) begin
                mem[WA]  <= DI;
                pend[WA] <= 1'b0;
            end
            // placed after the clear so a same-register issue wins
            if (iss_e) pend[ISSUE_RD] <= 1'b1;
            cnt <= cnt + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
            if (iss_e && pend[ISSUE_RD]) err <= 1'b1;
        end
    end

    assign OUTSTANDING = cnt;
    assign ERR         = err;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        toy_regfile_sb_rdport #(.AW(AW), .DW(DW)) u_rd (
            .mem  (mem),
            .pend (pend),
            .wen  (wen_e),
            .wa   (WA),
            .di   (DI),
            .ra   (RA[i*AW +: AW]),
            .dout (DOUT[i*DW +: DW]),
            .busy (BUSY[i])
        );
    end

endmodule

// File: tb/tb_toy_regfile_sb.sv
// Directed bench for toy_regfile_sb (AW=5, DW=32, NRD=2). Inputs change on the
// falling edge; outputs are sampled 1ns later, well away from the rising edge.
module tb_toy_regfile_sb;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int NRD = 2;

    logic              CLK;
    logic              RST;
    logic              WEN;
    logic [AW-1:0]     WA;
    logic [DW-1:0]     DI;
    logic [NRD*AW-1:0] RA;
    logic [NRD*DW-1:0] DOUT;
    logic              ISSUE;
    logic [AW-1:0]     ISSUE_RD;
    logic [NRD-1:0]    BUSY;
    logic [AW:0]       OUTSTANDING;
    logic              ERR;

    int n_chk  = 0;
    int n_pass = 0;

    toy_regfile_sb #(.AW(AW), .DW(DW), .NRD(NRD)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .WEN         (WEN),
        .WA          (WA),
        .DI          (DI),
        .RA          (RA),
        .DOUT        (DOUT),
        .ISSUE       (ISSUE),
        .ISSUE_RD    (ISSUE_RD),
        .BUSY        (BUSY),
        .OUTSTANDING (OUTSTANDING),
        .ERR         (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        RA = {a1, a0};
    endtask

    // one full cycle: the rising edge happens inside this wait
    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic idle();
        WEN = 1'b0; ISSUE = 1'b0;
    endtask

    initial begin
        RST = 1'b1; WEN = 1'b0; WA = '0; DI = '0; RA = '0;
        ISSUE = 1'b0; ISSUE_RD = '0;
        tick(); tick();
        RST = 1'b0;
        #1;

        // reset state: every address on both ports reads zero and not busy
        chk("rst_outstanding", OUTSTANDING, 0);
        chk("rst_err", ERR, 0);
        for (int a = 0; a < 32; a++) begin
            set_ra(a[AW-1:0], 5'(31 - a));
            #1;
            chk($sformatf("rst_dout0_a%0d", a), DOUT[0 +: DW], 0);
            chk($sformatf("rst_dout1_a%0d", a), DOUT[DW +: DW], 0);
            chk($sformatf("rst_busy_a%0d", a), BUSY, 0);
        end

        // write-through bypass on port 0, then stored value next cycle
        tick();
        WEN = 1'b1; WA = 5'd5; DI = 32'hDEADBEEF; set_ra(5'd5, 5'd6);
        #1;
        chk("byp_dout0", DOUT[0 +: DW], 32'hDEADBEEF);
        chk("byp_dout1_other", DOUT[DW +: DW], 0);
        tick();
        WEN = 1'b0;
        #1;
        chk("stored_dout0", DOUT[0 +: DW], 32'hDEADBEEF);
        // bypass on port 1
        WEN = 1'b1; WA = 5'd6; DI = 32'h12345678;
        #1;
        chk("byp_dout1", DOUT[DW +: DW], 32'h12345678);
        tick();
        idle();
        #1;
        chk("stored_dout1", DOUT[DW +: DW], 32'h12345678);

        // issue 3 then 7; BUSY not forwarded in the issuing cycle
        ISSUE = 1'b1; ISSUE_RD = 5'd3; set_ra(5'd3, 5'd7);
        #1;
        chk("busy_no_fwd_issue", BUSY, 2'b00);
        tick();
        ISSUE_RD = 5'd7;
        tick();
        idle();
        #1;
        chk("out_after_2_issue", OUTSTANDING, 2);
        chk("busy_3_7", BUSY, 2'b11);
        // write-back 3: not forwarded into BUSY this cycle
        WEN = 1'b1; WA = 5'd3; DI = 32'hAA;
        #1;
        chk("busy_no_fwd_wen", BUSY, 2'b11);
        tick();
        idle();
        #1;
        chk("out_after_wb3", OUTSTANDING, 1);
        chk("busy_after_wb3", BUSY, 2'b10);
        chk("dout_reg3", DOUT[0 +: DW], 32'hAA);

        // issue 4, then issue 4 + write 4 same cycle while pending
        ISSUE = 1'b1; ISSUE_RD = 5'd4; set_ra(5'd4, 5'd7);
        tick();
        #1;
        chk("out_after_issue4", OUTSTANDING, 2);
        chk("err_before_reissue", ERR, 0);
        WEN = 1'b1; WA = 5'd4; DI = 32'h11;
        tick();
        idle();
        #1;
        chk("same_reg_dout4", DOUT[0 +: DW], 32'h11);
        chk("same_reg_busy4", BUSY[0], 1);
        chk("same_reg_out", OUTSTANDING, 2);
        chk("same_reg_err", ERR, 1);

        // different registers: issue 8 (new) + write 7 (pending) -> net 0
        ISSUE = 1'b1; ISSUE_RD = 5'd8; WEN = 1'b1; WA = 5'd7; DI = 32'h77;
        set_ra(5'd7, 5'd8);
        tick();
        idle();
        #1;
        chk("diff_out", OUTSTANDING, 2);
        chk("diff_busy", BUSY, 2'b10);
        chk("diff_dout7", DOUT[0 +: DW], 32'h77);

        // write to a non-pending register: count unchanged
        WEN = 1'b1; WA = 5'd10; DI = 32'hA0A0;
        set_ra(5'd10, 5'd4);
        tick();
        idle();
        #1;
        chk("np_wen_out", OUTSTANDING, 2);
        chk("np_wen_dout", DOUT[0 +: DW], 32'hA0A0);

        // same register, not pending: issue + write -> +1, stays pending
        ISSUE = 1'b1; ISSUE_RD = 5'd12; WEN = 1'b1; WA = 5'd12; DI = 32'hC12;
        set_ra(5'd12, 5'd8);
        tick();
        idle();
        #1;
        chk("same_np_out", OUTSTANDING, 3);
        chk("same_np_busy", BUSY, 2'b11);
        chk("same_np_dout", DOUT[0 +: DW], 32'hC12);

        // reset with pending state; WEN/ISSUE in that cycle are ignored
        RST = 1'b1; WEN = 1'b1; WA = 5'd5; DI = 32'h99; ISSUE = 1'b1; ISSUE_RD = 5'd2;
        tick();
        RST = 1'b0; idle();
        set_ra(5'd5, 5'd2);
        #1;
        chk("rst2_out", OUTSTANDING, 0);
        chk("rst2_err", ERR, 0);
        chk("rst2_dout5", DOUT[0 +: DW], 0);
        chk("rst2_busy", BUSY, 2'b00);
        // write to a formerly pending register after reset
        WEN = 1'b1; WA = 5'd4; DI = 32'h44;
        set_ra(5'd4, 5'd12);
        tick();
        idle();
        #1;
        chk("post_rst_wb_out", OUTSTANDING, 0);
        chk("post_rst_wb_err", ERR, 0);
        chk("post_rst_wb_dout", DOUT[0 +: DW], 32'h44);

        // issue 9 twice in a row -> sticky ERR
        ISSUE = 1'b1; ISSUE_RD = 5'd9; set_ra(5'd9, 5'd0);
        tick();
        #1;
        chk("dup_err_first", ERR, 0);
        chk("dup_out_first", OUTSTANDING, 1);
        tick();
        idle();
        #1;
        chk("dup_err_second", ERR, 1);
        chk("dup_out_second", OUTSTANDING, 1);
        // retire 9: ERR must stay set
        WEN = 1'b1; WA = 5'd9; DI = 32'h9;
        tick();
        idle();
        tick(); tick();
        #1;
        chk("err_sticky", ERR, 1);
        chk("err_sticky_out", OUTSTANDING, 0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        chk("err_cleared", ERR, 0);

        // register 0 behaviour
        WEN = 1'b1; WA = 5'd0; DI = 32'h55; ISSUE = 1'b1; ISSUE_RD = 5'd0;
        set_ra(5'd0, 5'd1);
        #1;
`ifdef TOY_REGFILE_R0_ZERO_EN
        chk("r0_byp", DOUT[0 +: DW], 0);
`else
        chk("r0_byp", DOUT[0 +: DW], 32'h55);
`endif
        tick();
        idle();
        #1;
`ifdef TOY_REGFILE_R0_ZERO_EN
        chk("r0_dout", DOUT[0 +: DW], 0);
        chk("r0_busy", BUSY[0], 0);
        chk("r0_out", OUTSTANDING, 0);
`else
        chk("r0_dout", DOUT[0 +: DW], 32'h55);
        chk("r0_busy", BUSY[0], 1);
        chk("r0_out", OUTSTANDING, 1);
`endif
        chk("r0_err", ERR, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/toy_regfile_sb.md
TOY_REGFILE_SB -- requirements
Module: toy_regfile_sb

Interface
REQ-001 Parameter AW, default 5, register address width; ENTRY = 2**AW registers.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter NRD, default 2, number of read ports, legal range 1..4.
REQ-004 CLK  input  1  the only clock; all state updates on its rising edge.
REQ-005 RST  input  1  reset, synchronous and active-high.
REQ-006 WEN  input  1  write-back enable.
REQ-007 WA  input  AW  write-back address.
REQ-008 DI  input  DW  write-back data.
REQ-009 RA  input  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
REQ-010 DOUT  output  NRD*DW  read data; port i occupies bits [i*DW +: DW].
REQ-011 ISSUE  input  1  an instruction that will write ISSUE_RD is dispatched; marks that register pending.
REQ-012 ISSUE_RD  input  AW  destination register of the issuing instruction.
REQ-013 BUSY  output  NRD  BUSY[i] = pending bit of register RA port i (combinational).
REQ-014 OUTSTANDING  output  AW+1  count of registers currently pending.
REQ-015 ERR  output  1  sticky flag: ISSUE hit an already-pending register.

Function
REQ-016 Register array: ENTRY x DW; on WEN, mem[WA] <= DI at the clock edge.
REQ-017 Read is combinational, zero latency; DOUT port i = DI when WEN and WA == RA port i (write-through bypass), else mem[RA port i].
REQ-018 Scoreboard: one pending bit per register; ISSUE sets pend[ISSUE_RD]; WEN clears pend[WA].
REQ-019 ISSUE and WEN to the same register in the same cycle: data written, pend stays 1 (new issue wins), OUTSTANDING unchanged if it was already pending, else +1.
REQ-020 ISSUE and WEN to different registers in the same cycle: both effects apply; OUTSTANDING changes by (+1 if the issued register was not pending) + (-1 if the written register was pending).
REQ-021 WEN to a non-pending register: write performed; pending bits and OUTSTANDING unchanged; no error.
REQ-022 ISSUE to an already-pending register: pend stays 1, OUTSTANDING unchanged, ERR set to 1 on the next edge and held until RST.
REQ-023 OUTSTANDING always equals the population count of pend; it never wraps (maximum ENTRY fits AW+1 bits).
REQ-024 BUSY reflects registered pend state only; a same-cycle ISSUE or WEN is not forwarded into BUSY.

Reset
REQ-025 When RST is 1 at a clock edge: all registers <= 0, all pend <= 0, OUTSTANDING <= 0, ERR <= 0; WEN and ISSUE in that cycle are ignored.
REQ-026 After reset, DOUT = 0 for every address (absent same-cycle bypass) and BUSY = 0.
REQ-027 RST asserted while registers are pending discards all pending state; later WEN to those registers is treated per REQ-021.

Configuration
REQ-028 Macro TOY_REGFILE_R0_ZERO_EN defined: register 0 is hardwired zero -- writes to 0 are dropped, reads of 0 return 0 including the bypass case, ISSUE to 0 is ignored (no pend, no count, no ERR), BUSY for address 0 is always 0.
REQ-029 Macro TOY_REGFILE_R0_ZERO_EN undefined: register 0 behaves as any other register.

Verification
REQ-030 Reset, then read all 32 addresses on both ports -> DOUT = 0, BUSY = 0, OUTSTANDING = 0, ERR = 0.
REQ-031 WEN=1 WA=5 DI=0xDEADBEEF with RA0=5 in the same cycle -> DOUT0 = 0xDEADBEEF combinationally; the next cycle with WEN=0 still reads 0xDEADBEEF.
REQ-032 ISSUE rd=3, then ISSUE rd=7 -> OUTSTANDING=2, BUSY[RA=3]=1; WEN WA=3 -> OUTSTANDING=1, BUSY[RA=3]=0.
REQ-033 Same cycle ISSUE rd=4 and WEN WA=4 DI=0x11 with reg 4 pending -> mem[4]=0x11, pend[4]=1, OUTSTANDING unchanged.
REQ-034 ISSUE rd=9 twice on consecutive cycles -> ERR=1 from the second edge, OUTSTANDING=1; ERR stays 1 until RST.
REQ-035 With TOY_REGFILE_R0_ZERO_EN: WEN WA=0 DI=0x55 plus ISSUE rd=0 -> DOUT for RA=0 = 0, BUSY=0, OUTSTANDING=0; without the macro -> DOUT=0x55, OUTSTANDING=1.
